dbg_seq: RTL and testbench

Host-side sequencer that drives `dbg_module`'s command port so a test host can issue block operations instead of single commands. Supported operations are block write, block read, core reset and full reset, with optional core halt before and resume after. It enforces the one-command-at-a-time handshake, inserts the mandatory idle (`8'h00`) cycle between commands, auto-increments addresses, and aborts on a handshake timeout. It sits between the host/testbench bridge and `dbg_module`.

---
 rtl/dbg_seq.sv | 219 +++++++++++++++++++++
 tb/tb_dbg_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_seq.sv
// dbg_seq: turns host block requests into single dbg_module commands.
// Optional halt, a block/reset body and optional resume, one command at a time with idle gaps.
module dbg_seq #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [15:0] req_len_i,
  input  logic        req_halt_i,
  input  logic        req_resume_i,
  input  logic [31:0] wdata_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);

  // state | meaning
  // IDLE  | waiting for a request
  // FETCH | block write waiting for the next host word
  // ISSUE | command driven, waiting for dbg_ready_i low (reset cmds: one cycle)
  // WAIT  | command held until dbg_ready_i returns high
  // GAP   | one idle (00) cycle between commands
  // DONE  | one-cycle done_o pulse
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {P_HALT, P_BODY, P_RESUME} phase_t;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RST   = 2'b10;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_READ     = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_HALT     = 8'h03;
  localparam logic [7:0] CMD_RESUME   = 8'h04;
  localparam logic [7:0] CMD_RST_CORE = 8'h05;
  localparam logic [7:0] CMD_RST_ALL  = 8'h07;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  state_t        tail_state, body_state;
  phase_t        tail_phase, body_phase;
  logic [1:0]    op, op_c;
  logic [31:0]   addr, addr_c;
  logic [15:0]   cnt, cnt_c;
  logic          resume, resume_c;
  logic [TW-1:0] tmo;
  logic [31:0]   cmd_addr, cmd_data, rdata;
  logic          rdata_valid, err;
  logic [7:0]    cur_cmd, cmd;
  logic          accept, cmd_done, abort, tmo_hit, is_reset_cmd;

  assign accept       = req_valid_i && (state == S_IDLE);
  assign tmo_hit      = (tmo == '0);
  assign is_reset_cmd = (phase == P_BODY) && op[1];

  // While idle, the decision for the accept edge uses the request fields directly.
  always_comb begin
    op_c     = (state == S_IDLE) ? req_op_i     : op;
    addr_c   = (state == S_IDLE) ? req_addr_i   : addr;
    cnt_c    = (state == S_IDLE) ? req_len_i    : cnt;
    resume_c = (state == S_IDLE) ? req_resume_i : resume;
  end

  always_comb begin
    tail_state = resume_c ? S_ISSUE : S_DONE;
    tail_phase = P_RESUME;
    if (!op_c[1] && cnt_c == '0) begin
      body_state = tail_state;
      body_phase = tail_phase;
    end else begin
      body_state = (op_c == OP_WRITE) ? S_FETCH : S_ISSUE;
      body_phase = P_BODY;
    end
  end

  always_comb begin
    cur_cmd = CMD_NOP;
    case (phase)
      P_HALT:   cur_cmd = CMD_HALT;
      P_RESUME: cur_cmd = CMD_RESUME;
      default: begin
        case (op)
          OP_WRITE: cur_cmd = CMD_WRITE;
          OP_READ:  cur_cmd = CMD_READ;
          OP_RST:   cur_cmd = CMD_RST_CORE;
          default:  cur_cmd = CMD_RST_ALL;
        endcase
      end
    endcase
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    cmd      = CMD_NOP;
    cmd_done = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_halt_i) begin
            state_n = S_ISSUE;
            phase_n = P_HALT;
          end else begin
            state_n = body_state;
            phase_n = body_phase;
          end
        end
      end
      S_FETCH: begin
        if (wdata_valid_i) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        cmd = cur_cmd;
        if (is_reset_cmd) begin
          state_n = S_GAP;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = S_GAP;
        end else if (!dbg_ready_i) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Drop the command in the completing cycle so it is not executed twice.
        if (dbg_ready_i) begin
          cmd_done = 1'b1;
          state_n  = S_GAP;
        end else if (tmo_hit) begin
          cmd     = cur_cmd;
          abort   = 1'b1;
          state_n = S_GAP;
        end else begin
          cmd = cur_cmd;
        end
      end
      S_GAP: begin
        if (phase == P_RESUME) begin
          state_n = S_DONE;
        end else if (err || is_reset_cmd) begin
          state_n = tail_state;
          phase_n = tail_phase;
        end else begin
          state_n = body_state;
          phase_n = body_phase;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= S_IDLE;
      phase       <= P_HALT;
      op          <= '0;
      addr        <= '0;
      cnt         <= '0;
      resume      <= 1'b0;
      tmo         <= TMO_LOAD;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      rdata_valid <= 1'b0;
      if (accept) begin
        op     <= req_op_i;
        addr   <= req_addr_i;
        cnt    <= req_len_i;
        resume <= req_resume_i;
        err    <= 1'b0;
      end
      if (abort) err <= 1'b1;
      tmo <= (state == S_ISSUE || state == S_WAIT) ? tmo - 1'b1 : TMO_LOAD;
      if (state == S_FETCH && wdata_valid_i) cmd_data <= wdata_i;
      if (state_n == S_ISSUE && phase_n == P_BODY && !op_c[1]) cmd_addr <= addr_c;
      if (cmd_done && phase == P_BODY) begin
        addr <= addr + 32'd4;
        cnt  <= cnt - 16'd1;
        if (op == OP_READ) begin
          rdata       <= dbg_data_i;
          rdata_valid <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o   = (state == S_IDLE);
  assign wdata_ready_o = (state == S_FETCH);
  assign done_o        = (state == S_DONE);
  assign err_o         = err;
  assign rdata_o       = rdata;
  assign rdata_valid_o = rdata_valid;
  assign dbg_cmd_o     = cmd;
  assign dbg_addr_o    = cmd_addr;
  assign dbg_data_o    = cmd_data;

endmodule

// File: tb/tb_dbg_seq.sv
// tb_dbg_seq: directed checks of dbg_seq against a small registered dbg_module model.
module tb_dbg_seq;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [15:0] req_len_i;
  logic        req_halt_i;
  logic        req_resume_i;
  logic [31:0] wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i;
  logic        dbg_ready_i;

  dbg_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_halt_i(req_halt_i),
    .req_resume_i(req_resume_i), .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .err_o(err_o), .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o),
    .dbg_data_o(dbg_data_o), .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model / monitor state
  int          lat = 0;
  int          busy = 0;
  bit          stuck_read = 1'b0;
  logic [7:0]  pend_cmd = 8'h00;
  logic [31:0] rd_q [0:7];
  int          rd_idx = 0;
  logic [31:0] wq [0:7];
  int          n_w = 0;
  int          widx = 0;
  logic [7:0]  exec_cmd [0:15];
  logic [31:0] exec_addr [0:15];
  logic [31:0] exec_data [0:15];
  int          n_exec = 0;
  bit          trace_on = 1'b0;
  logic [7:0]  run_val [0:31];
  int          run_len [0:31];
  int          n_runs = 0;
  int          n_done = 0;
  logic [31:0] rv_val [0:7];
  int          n_rv = 0;
  int          n_wready = 0;
  logic [7:0]  s_cmd;
  logic [31:0] s_addr, s_data;
  logic        s_ready, s_take;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Registered dbg_module stand-in: samples mid-cycle, reacts just after the next edge.
  initial begin
    dbg_ready_i   = 1'b1;
    dbg_data_i    = 32'h0;
    wdata_i       = 32'h0;
    wdata_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      s_cmd   = dbg_cmd_o;
      s_addr  = dbg_addr_o;
      s_data  = dbg_data_o;
      s_ready = dbg_ready_i;
      s_take  = wdata_ready_o && wdata_valid_i;
      if (trace_on) begin
        if (n_runs > 0 && run_val[n_runs-1] == dbg_cmd_o) run_len[n_runs-1]++;
        else if (n_runs < 32) begin
          run_val[n_runs] = dbg_cmd_o;
          run_len[n_runs] = 1;
          n_runs++;
        end
        if (done_o) trace_on = 1'b0;
      end
      if (done_o) n_done++;
      if (rdata_valid_o && n_rv < 8) begin
        rv_val[n_rv] = rdata_o;
        n_rv++;
      end
      if (wdata_ready_o) n_wready++;
      @(posedge clk);
      #1;
      if (s_take) widx++;
      wdata_valid_i = (widx < n_w);
      wdata_i       = (widx < n_w) ? wq[widx] : 32'h0;
      if (s_ready) begin
        if (s_cmd == 8'h05 || s_cmd == 8'h07 ||
            (s_cmd >= 8'h01 && s_cmd <= 8'h04 && !(stuck_read && s_cmd == 8'h01))) begin
          if (n_exec < 16) begin
            exec_cmd[n_exec]  = s_cmd;
            exec_addr[n_exec] = s_addr;
            exec_data[n_exec] = s_data;
          end
          n_exec++;
          if (s_cmd <= 8'h04) begin
            dbg_ready_i = 1'b0;
            busy        = lat;
            pend_cmd    = s_cmd;
          end
        end
      end else if (busy > 0) begin
        busy--;
      end else begin
        dbg_ready_i = 1'b1;
        if (pend_cmd == 8'h01) begin
          dbg_data_i = rd_q[rd_idx];
          rd_idx++;
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [15:0] len,
                        input logic halt, input logic resume);
    @(posedge clk);
    #2;
    n_exec = 0; n_runs = 0; n_done = 0; n_rv = 0; n_wready = 0; rd_idx = 0;
    req_op_i = op; req_addr_i = addr; req_len_i = len;
    req_halt_i = halt; req_resume_i = resume; req_valid_i = 1'b1;
    @(posedge clk);
    #2;
    req_valid_i = 1'b0;
    trace_on    = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (!trace_on) break;
    end
    check({tag, "_done_bound"}, 32'(trace_on), 32'd0);
    trace_on = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
  endtask

  task automatic exp_run(input string tag, input int idx, input logic [7:0] v, input int l);
    check($sformatf("%s_run%0d_cmd", tag, idx), 32'(run_val[idx]), 32'(v));
    check($sformatf("%s_run%0d_len", tag, idx), 32'(run_len[idx]), 32'(l));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00; req_addr_i = 32'h0;
    req_len_i = 16'h0; req_halt_i = 1'b0; req_resume_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cmd", 32'(dbg_cmd_o), 32'd0);
    check("rst_addr", dbg_addr_o, 32'd0);
    check("rst_data", dbg_data_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);

    // block write, 3 words
    lat = 0;
    wq[0] = 32'hA; wq[1] = 32'hB; wq[2] = 32'hC; widx = 0; n_w = 3;
    do_req(2'b00, 32'h1000, 16'd3, 1'b0, 1'b0);
    wait_done("wr");
    check("wr_exec_n", 32'(n_exec), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr%0d_cmd", i), 32'(exec_cmd[i]), 32'h02);
      check($sformatf("wr%0d_addr", i), exec_addr[i], 32'h1000 + 32'(4 * i));
      check($sformatf("wr%0d_data", i), exec_data[i], 32'hA + 32'(i));
    end
    check("wr_wready_cycles", 32'(n_wready), 32'd3);
    check("wr_n_runs", 32'(n_runs), 32'd7);
    exp_run("wr", 0, 8'h00, 1);
    exp_run("wr", 1, 8'h02, 2);
    exp_run("wr", 2, 8'h00, 3);
    exp_run("wr", 3, 8'h02, 2);
    exp_run("wr", 4, 8'h00, 3);
    exp_run("wr", 5, 8'h02, 2);
    exp_run("wr", 6, 8'h00, 3);
    check("wr_addr_hold", dbg_addr_o, 32'h1008);
    check("wr_data_hold", dbg_data_o, 32'hC);
    n_w = 0;

    // block read across the address wrap
    lat = 1;
    rd_q[0] = 32'h11; rd_q[1] = 32'h22;
    do_req(2'b01, 32'hFFFF_FFFC, 16'd2, 1'b0, 1'b0);
    wait_done("rd");
    check("rd_exec_n", 32'(n_exec), 32'd2);
    check("rd0_cmd", 32'(exec_cmd[0]), 32'h01);
    check("rd0_addr", exec_addr[0], 32'hFFFF_FFFC);
    check("rd1_cmd", 32'(exec_cmd[1]), 32'h01);
    check("rd1_addr", exec_addr[1], 32'h0000_0000);
    check("rd_valid_n", 32'(n_rv), 32'd2);
    check("rd_data0", rv_val[0], 32'h11);
    check("rd_data1", rv_val[1], 32'h22);

    // halt + zero-length write + resume
    lat = 0;
    do_req(2'b00, 32'h4000, 16'd0, 1'b1, 1'b1);
    wait_done("hl0");
    check("hl0_wready_cycles", 32'(n_wready), 32'd0);
    check("hl0_exec_n", 32'(n_exec), 32'd2);
    check("hl0_n_runs", 32'(n_runs), 32'd4);
    exp_run("hl0", 0, 8'h03, 2);
    exp_run("hl0", 1, 8'h00, 2);
    exp_run("hl0", 2, 8'h04, 2);
    exp_run("hl0", 3, 8'h00, 3);

    // reset core with halt/resume
    do_req(2'b10, 32'h0, 16'd0, 1'b1, 1'b1);
    wait_done("rstc");
    check("rstc_exec_n", 32'(n_exec), 32'd3);
    check("rstc_exec1", 32'(exec_cmd[1]), 32'h05);
    check("rstc_n_runs", 32'(n_runs), 32'd6);
    exp_run("rstc", 0, 8'h03, 2);
    exp_run("rstc", 1, 8'h00, 2);
    exp_run("rstc", 2, 8'h05, 1);
    exp_run("rstc", 3, 8'h00, 1);
    exp_run("rstc", 4, 8'h04, 2);
    exp_run("rstc", 5, 8'h00, 3);

    // timeout on a read that is never acknowledged
    stuck_read = 1'b1;
    do_req(2'b01, 32'h2000, 16'd4, 1'b0, 1'b1);
    wait_done("tmo");
    stuck_read = 1'b0;
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_rvalid_n", 32'(n_rv), 32'd0);
    check("tmo_exec_n", 32'(n_exec), 32'd1);
    check("tmo_exec0", 32'(exec_cmd[0]), 32'h04);
    check("tmo_n_runs", 32'(n_runs), 32'd4);
    exp_run("tmo", 0, 8'h01, 16);
    exp_run("tmo", 1, 8'h00, 1);
    exp_run("tmo", 2, 8'h04, 2);
    exp_run("tmo", 3, 8'h00, 3);
    do_req(2'b01, 32'h0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("tmo_err_cleared", 32'(err_o), 32'd0);
    check("len0_done_now", 32'(done_o), 32'd1);
    wait_done("len0");

    // reset during the second write of five
    lat = 3;
    for (int i = 0; i < 5; i++) wq[i] = 32'(i + 1);
    widx = 0; n_w = 5;
    do_req(2'b00, 32'h3000, 16'd5, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_exec >= 2) break;
    end
    check("mid_second_write_seen", 32'(n_exec), 32'd2);
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    check("mid_cmd", 32'(dbg_cmd_o), 32'd0);
    check("mid_req_ready", 32'(req_ready_o), 32'd1);
    check("mid_wready", 32'(wdata_ready_o), 32'd0);
    check("mid_no_done", 32'(n_done), 32'd0);
    rst_i = 1'b0;
    trace_on = 1'b0;
    n_w = 0;
    repeat (10) @(negedge clk);
    #1;
    check("mid_no_done_later", 32'(n_done), 32'd0);
    check("mid_no_more_cmds", 32'(n_exec), 32'd2);
    check("mid_idle_ready", 32'(req_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
